// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared core constants and types: register file geometry,
//                writeback request record and writeback requester indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One writeback source: result valid, destination register and value.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Writeback requester indices on the arbiter.
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter with a one-hot, purely combinational
//                grant. The priority pointer starts at requester 0 and moves
//                to the slot after the winner whenever a grant is accepted.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   asynchronous active-high reset (pointer -> 0)
//    req      in   [N]  request vector
//    advance  in   grant accepted this cycle; moves the pointer
//    grant    out  [N]  one-hot grant, subset of req
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [N-1:0]     w_hi_grant;
    logic [N-1:0]     w_lo_grant;
    logic             w_hi_found;
    logic             w_lo_found;

    // Two priority scans: the lowest requester at or above the pointer, and
    // the lowest requester overall. The latter is the wrap-around winner,
    // used only when nothing at or above the pointer is requesting.
    always_comb begin
        w_hi_grant = '0;
        w_lo_grant = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (!w_lo_found) begin
                    w_lo_grant[i] = 1'b1;
                    w_lo_found    = 1'b1;
                end
                if (!w_hi_found && (i >= int'(r_ptr))) begin
                    w_hi_grant[i] = 1'b1;
                    w_hi_found    = 1'b1;
                end
            end
        end
        grant = w_hi_found ? w_hi_grant : w_lo_grant;
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Writeback controller for the 32x32 register file. Arbitrates
//                N_REQ writeback sources (0=ALU, 1=LSU, 2=MDU) round-robin
//                onto the single write port through one registered writeback
//                stage, and keeps a per-register busy scoreboard for RAW
//                hazard detection at issue.
//                Optional macro WBARB_BYPASS_EN: forward the writeback-stage
//                value to matching source reads and mask their busy bit.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    req_valid/ready          [N_REQ] per-source handshake (ready = grant)
//    req_rd, req_data         per-source destination and result
//    iss_valid, iss_rd        issuing instruction's destination (sets busy)
//    rs1_addr, rs2_addr       issue-stage source register queries
//    rs1_busy, rs2_busy       outstanding-write hazard per source
//    fwd1/2_valid, _data      bypass hit and data (0 without the macro)
//    rf_we, rf_wr_addr/data   register file write port
// ============================================================================
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][REG_ADDR_W-1:0] req_rd,
    input  logic [N_REQ-1:0][XLEN-1:0]       req_data,
    input  logic                            iss_valid,
    input  logic [REG_ADDR_W-1:0]           iss_rd,
    input  logic [REG_ADDR_W-1:0]           rs1_addr,
    input  logic [REG_ADDR_W-1:0]           rs2_addr,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    output logic                            fwd1_valid,
    output logic                            fwd2_valid,
    output logic [XLEN-1:0]                 fwd1_data,
    output logic [XLEN-1:0]                 fwd2_data,
    output logic                            rf_we,
    output logic [REG_ADDR_W-1:0]           rf_wr_addr,
    output logic [XLEN-1:0]                 rf_wr_data
);

    logic [N_REQ-1:0]      w_grant;
    logic                  w_advance;
    logic [REG_ADDR_W-1:0] w_win_rd;
    logic [XLEN-1:0]       w_win_data;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_advance),
        .grant   (w_grant)
    );

    // The grant is already a subset of req_valid, so any grant is a transfer.
    assign req_ready = w_grant;
    assign w_advance = |(req_valid & w_grant);

    always_comb begin
        w_win_rd   = '0;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_rd   = req_rd[i];
                w_win_data = req_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback stage. A grant to x0 is consumed but never writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_advance && (w_win_rd != '0);
            if (w_advance) begin
                r_addr <= w_win_rd;
                r_data <= w_win_data;
            end
        end
    end

    assign rf_we      = r_we;
    assign rf_wr_addr = r_addr;
    assign rf_wr_data = r_data;

    // ------------------------------------------------------------------
    // Busy scoreboard. The clear from the write port is applied first so a
    // same-cycle issue to the same register leaves it busy (new producer).
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_busy_nxt[i] = (r_busy[i] && !(r_we && (r_addr == REG_ADDR_W'(i))))
                          || (iss_valid && (iss_rd == REG_ADDR_W'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Source queries and optional bypass
    // ------------------------------------------------------------------
`ifdef WBARB_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1     = r_we && (r_addr == rs1_addr) && (rs1_addr != '0);
    assign w_hit2     = r_we && (r_addr == rs2_addr) && (rs2_addr != '0);
    assign fwd1_valid = w_hit1;
    assign fwd2_valid = w_hit2;
    assign fwd1_data  = w_hit1 ? r_data : '0;
    assign fwd2_data  = w_hit2 ? r_data : '0;
    // The value being written is forwarded, so the read is not a hazard.
    assign rs1_busy   = r_busy[rs1_addr] && !w_hit1;
    assign rs2_busy   = r_busy[rs2_addr] && !w_hit2;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
    assign rs1_busy   = r_busy[rs1_addr];
    assign rs2_busy   = r_busy[rs2_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter: reset values,
//                a directed cycle table (round-robin, scoreboard, set/clear
//                collision, x0 writes), an asynchronous mid-stream reset and
//                a randomized run against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import riscv_pkg::*;

    localparam int N  = 3;
    localparam int XL = 32;
`ifdef WBARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][4:0]    req_rd;
    logic [N-1:0][XL-1:0] req_data;
    logic                 iss_valid;
    logic [4:0]           iss_rd;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 fwd1_valid;
    logic                 fwd2_valid;
    logic [XL-1:0]        fwd1_data;
    logic [XL-1:0]        fwd2_data;
    logic                 rf_we;
    logic [4:0]           rf_wr_addr;
    logic [XL-1:0]        rf_wr_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .fwd1_valid (fwd1_valid),
        .fwd2_valid (fwd2_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
        .rf_we      (rf_we),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int i, input logic [4:0] rd);
        return 32'hC0DE_0000 | (32'(i) << 8) | 32'(rd);
    endfunction

    // ------------------------------------------------------------------
    // Directed cycle table, applied from a fresh reset
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]      valid;
        logic [2:0][4:0] rd;
        logic            iss_v;
        logic [4:0]      iss_rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      ready;
        logic            we;
        logic            ck_addr;
        logic [4:0]      addr;
        logic            busy1;
        logic            busy2;
    } row_t;

    function automatic row_t mk(input logic [2:0] v, input logic [4:0] r2, input logic [4:0] r1,
                                input logic [4:0] r0, input logic iv, input logic [4:0] ird,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] rdy,
                                input logic we, input logic ck, input logic [4:0] ad,
                                input logic b1, input logic b2);
        row_t t;
        t.valid = v;   t.rd[2] = r2; t.rd[1] = r1; t.rd[0] = r0;
        t.iss_v = iv;  t.iss_rd = ird; t.rs1 = s1; t.rs2 = s2;
        t.ready = rdy; t.we = we; t.ck_addr = ck; t.addr = ad;
        t.busy1 = b1;  t.busy2 = b2;
        return t;
    endfunction

    row_t tbl [16];

    // Reference model state for the randomized phase
    int              m_ptr;
    bit              m_busy [32];
    bit              m_we;
    logic [4:0]      m_addr;
    logic [31:0]     m_data;
    bit              cur_valid [N];
    logic [4:0]      cur_rd    [N];
    logic [31:0]     cur_data  [N];

    task automatic new_req(input int i);
        cur_valid[i] = ($urandom_range(0, 99) < 60);
        cur_rd[i]    = 5'($urandom_range(0, 7));
        cur_data[i]  = $urandom;
    endtask

    initial begin
        logic [31:0] prev_data;
        logic        hit1;
        logic        hit2;
        int          g;
        logic [2:0]  exp_ready;

        //              v      r2 r1 r0 iv ird rs1 rs2 ready  we ck addr b1 b2
        tbl[0]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b001, 0, 1, 0,  0, 0);
        tbl[1]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b010, 1, 1, 1,  0, 0);
        tbl[2]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b100, 1, 1, 2,  0, 0);
        tbl[3]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b001, 1, 1, 3,  0, 0);
        tbl[4]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b010, 1, 1, 1,  0, 0);
        tbl[5]  = mk(3'b111, 3, 2, 1, 0, 0,  1,  2, 3'b100, 1, 1, 2,  0, 0);
        tbl[6]  = mk(3'b000, 0, 0, 0, 1, 7,  7,  0, 3'b000, 1, 1, 3,  0, 0);
        tbl[7]  = mk(3'b010, 0, 7, 0, 0, 0,  7,  0, 3'b010, 0, 1, 3,  1, 0);
        tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0,  7,  0, 3'b000, 1, 1, 7,  1, 0);
        tbl[9]  = mk(3'b100, 9, 0, 0, 1, 9,  7,  9, 3'b100, 0, 1, 7,  0, 0);
        tbl[10] = mk(3'b000, 0, 0, 0, 1, 9,  9,  7, 3'b000, 1, 1, 9,  1, 0);
        tbl[11] = mk(3'b001, 0, 0, 0, 1, 0,  9,  0, 3'b001, 0, 1, 9,  1, 0);
        tbl[12] = mk(3'b000, 0, 0, 0, 0, 0,  0,  9, 3'b000, 0, 0, 0,  0, 1);
        tbl[13] = mk(3'b010, 0, 9, 0, 0, 0,  0,  9, 3'b010, 0, 0, 0,  0, 1);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0,  0,  9, 3'b000, 1, 1, 9,  0, 1);
        tbl[15] = mk(3'b000, 0, 0, 0, 0, 0,  0,  9, 3'b000, 0, 1, 9,  0, 0);

        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
        iss_valid = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rf_we",   32'(rf_we),      32'd0);
        chk("reset_addr",    32'(rf_wr_addr), 32'd0);
        chk("reset_data",    rf_wr_data,      32'd0);
        chk("reset_ready",   32'(req_ready),  32'd0);
        chk("reset_busy1",   32'(rs1_busy),   32'd0);
        chk("reset_fwd1",    32'(fwd1_valid), 32'd0);

        // ---------------- directed table ----------------
        prev_data = '0;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            req_valid = tbl[r].valid;
            for (int i = 0; i < N; i++) begin
                req_rd[i]   = tbl[r].rd[i];
                req_data[i] = data_of(i, tbl[r].rd[i]);
            end
            iss_valid = tbl[r].iss_v;
            iss_rd    = tbl[r].iss_rd;
            rs1_addr  = tbl[r].rs1;
            rs2_addr  = tbl[r].rs2;
            #1;
            hit1 = BYP && tbl[r].we && (tbl[r].addr == tbl[r].rs1) && (tbl[r].rs1 != 0);
            hit2 = BYP && tbl[r].we && (tbl[r].addr == tbl[r].rs2) && (tbl[r].rs2 != 0);
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            chk($sformatf("tbl%0d_rf_we", r), 32'(rf_we),     32'(tbl[r].we));
            if (tbl[r].ck_addr)
                chk($sformatf("tbl%0d_addr", r), 32'(rf_wr_addr), 32'(tbl[r].addr));
            if (tbl[r].we)
                chk($sformatf("tbl%0d_data", r), rf_wr_data, prev_data);
            chk($sformatf("tbl%0d_busy1", r), 32'(rs1_busy), 32'(tbl[r].busy1 && !hit1));
            chk($sformatf("tbl%0d_busy2", r), 32'(rs2_busy), 32'(tbl[r].busy2 && !hit2));
            chk($sformatf("tbl%0d_fwd1v", r), 32'(fwd1_valid), 32'(hit1));
            chk($sformatf("tbl%0d_fwd2d", r), fwd2_data, hit2 ? prev_data : 32'd0);
            for (int i = 0; i < N; i++)
                if (tbl[r].ready[i]) prev_data = data_of(i, tbl[r].rd[i]);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        @(negedge clk);
        req_valid = 3'b001; req_rd[0] = 5'd12; req_data[0] = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_rd = 5'd12; rs1_addr = 5'd12; rs2_addr = 5'd0;
        @(negedge clk);
        req_valid = '0; iss_valid = 1'b0;
        #1;
        chk("pre_rst_rf_we", 32'(rf_we),    32'd1);
        chk("pre_rst_busy1", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rf_we", 32'(rf_we),      32'd0);
        chk("async_rst_addr",  32'(rf_wr_addr), 32'd0);
        chk("async_rst_data",  rf_wr_data,      32'd0);
        chk("async_rst_busy1", 32'(rs1_busy),   32'd0);
        chk("async_rst_fwd1",  fwd1_data,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 3'b111;
        req_rd[0] = 5'd5; req_rd[1] = 5'd6; req_rd[2] = 5'd8;
        req_data[0] = 32'h0000_0555; req_data[1] = 32'h0000_0666; req_data[2] = 32'h0000_0888;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("post_rst_rf_we", 32'(rf_we),      32'd1);
        chk("post_rst_addr",  32'(rf_wr_addr), 32'd5);
        chk("post_rst_data",  rf_wr_data,      32'h0000_0555);

        // ---------------- randomized run against the model ----------------
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        for (int i = 0; i < N; i++) new_req(i);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = cur_valid[i];
                req_rd[i]    = cur_rd[i];
                req_data[i]  = cur_data[i];
            end
            iss_valid = ($urandom_range(0, 99) < 30);
            iss_rd    = 5'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));

            // First valid requester at or after the pointer, wrapping.
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && cur_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;

            hit1 = BYP && m_we && (m_addr == rs1_addr) && (rs1_addr != 0);
            hit2 = BYP && m_we && (m_addr == rs2_addr) && (rs2_addr != 0);
            #1;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_rf_we", 32'(rf_we), 32'(m_we));
            if (m_we) begin
                chk("rnd_addr", 32'(rf_wr_addr), 32'(m_addr));
                chk("rnd_data", rf_wr_data, m_data);
            end
            chk("rnd_busy1", 32'(rs1_busy), 32'(m_busy[rs1_addr] && !hit1));
            chk("rnd_busy2", 32'(rs2_busy), 32'(m_busy[rs2_addr] && !hit2));
            chk("rnd_fwd1v", 32'(fwd1_valid), 32'(hit1));
            chk("rnd_fwd2v", 32'(fwd2_valid), 32'(hit2));
            chk("rnd_fwd1d", fwd1_data, hit1 ? m_data : 32'd0);
            chk("rnd_fwd2d", fwd2_data, hit2 ? m_data : 32'd0);

            // Scoreboard: write clears, issue sets, issue wins on collision.
            if (m_we) m_busy[m_addr] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (g >= 0) begin
                m_we   = (cur_rd[g] != 0);
                m_addr = cur_rd[g];
                m_data = cur_data[g];
                m_ptr  = (g + 1) % N;
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (!cur_valid[i] || g == i) new_req(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
